// File: rtl/itch_order_encoder_if.sv
// Request and egress signals of the ITCH order encoder, grouped as one bundle.
// The slave modport is the encoder's view; master is the quoting-logic/framer view.
interface itch_order_encoder_if #(
  parameter int REG_WIDTH  = 32,
  parameter int QTY_WIDTH  = 16,
  parameter int NUM_STOCKS = 4
);
  localparam int SYM_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  logic                 i_data_valid;
  logic                 o_ready;
  logic [1:0]           i_msg_type;
  logic                 i_trade_type;
  logic [SYM_W-1:0]     i_stock_symbol;
  logic [REG_WIDTH-1:0] i_buy_price;
  logic [REG_WIDTH-1:0] i_sell_price;
  logic [QTY_WIDTH-1:0] i_quantity;
  logic [REG_WIDTH-1:0] i_order_ref;
  logic                 i_book_is_busy;
  logic                 i_ready;
  logic                 o_valid;
  logic [REG_WIDTH-1:0] o_reg_1;
  logic [REG_WIDTH-1:0] o_reg_2;
  logic [REG_WIDTH-1:0] o_reg_3;
  logic [REG_WIDTH-1:0] o_reg_4;
  logic [REG_WIDTH-1:0] o_reg_5;
  logic [REG_WIDTH-1:0] o_reg_6;
  logic [REG_WIDTH-1:0] o_reg_7;
  logic [REG_WIDTH-1:0] o_order_id;
  logic                 o_drop;

  modport slave (
    input  i_data_valid, i_msg_type, i_trade_type, i_stock_symbol,
           i_buy_price, i_sell_price, i_quantity, i_order_ref,
           i_book_is_busy, i_ready,
    output o_ready, o_valid, o_reg_1, o_reg_2, o_reg_3, o_reg_4,
           o_reg_5, o_reg_6, o_reg_7, o_order_id, o_drop
  );

  modport master (
    output i_data_valid, i_msg_type, i_trade_type, i_stock_symbol,
           i_buy_price, i_sell_price, i_quantity, i_order_ref,
           i_book_is_busy, i_ready,
    input  o_ready, o_valid, o_reg_1, o_reg_2, o_reg_3, o_reg_4,
           o_reg_5, o_reg_6, o_reg_7, o_order_id, o_drop
  );
endinterface

// File: rtl/itch_order_encoder.sv
// ITCH outbound encoder: stamps order requests with time/reference, packs them into
// seven registers and buffers them in a show-ahead FIFO toward the transmit framer.
module itch_order_encoder #(
  parameter int                   REG_WIDTH      = 32,
  parameter int                   QTY_WIDTH      = 16,
  parameter int                   NUM_STOCKS     = 4,
  parameter int                   FIFO_DEPTH     = 4,
  parameter logic [REG_WIDTH-1:0] ORDER_ID_START = {{(REG_WIDTH-1){1'b0}}, 1'b1}
) (
  input logic                i_clk,
  input logic                i_reset,
  itch_order_encoder_if.slave bus
);

  localparam int SYM_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    MSG_ADD      = 2'd0,
    MSG_CANCEL   = 2'd1,
    MSG_EXECUTE  = 2'd2,
    MSG_RESERVED = 2'd3
  } msg_type_e;

  // Element [0] carries reg_1, element [6] carries reg_7.
  typedef logic [6:0][REG_WIDTH-1:0] msg_t;

  msg_t                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [REG_WIDTH-1:0] timestamp_q, timestamp_d;
  logic [REG_WIDTH-1:0] idCount_q, idCount_d;
  logic [REG_WIDTH-1:0] orderId_q, orderId_d;
  logic                 drop_q, drop_d;

  msg_type_e msgType;
  logic      fifoFull;
  logic      fifoEmpty;
  logic      accept;
  logic      push;
  logic      pop;
  msg_t      newMsg;
  msg_t      headMsg;
  logic [7:0]  msgCode;
  logic [63:0] symbolName;

  function automatic logic [63:0] lookupSymbol(input logic [SYM_W-1:0] sym);
    logic [63:0] name;
    name = '0;
    case (32'(sym))
      0:       name = 64'h4141504C_20202020;
      1:       name = 64'h414D5A4E_20202020;
      2:       name = 64'h474F4F47_4C202020;
      3:       name = 64'h4D534654_20202020;
      default: name = '0;
    endcase
    return name;
  endfunction

  assign msgType   = msg_type_e'(bus.i_msg_type);
  assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (count_q == '0);

  // A same-cycle pop deliberately does not open a slot: ready depends only on registered state.
  assign bus.o_ready = !i_reset && !fifoFull && !bus.i_book_is_busy;
  assign accept      = bus.i_data_valid && bus.o_ready;
  assign push        = accept && (msgType != MSG_RESERVED);
  assign pop         = !fifoEmpty && bus.i_ready;

  always_comb begin
    msgCode    = 8'h00;
    symbolName = lookupSymbol(bus.i_stock_symbol);
    newMsg     = '0;
    case (msgType)
      MSG_ADD:     msgCode = 8'h41;
      MSG_CANCEL:  msgCode = 8'h58;
      MSG_EXECUTE: msgCode = 8'h45;
      default:     msgCode = 8'h00;
    endcase
    newMsg[0] = REG_WIDTH'({msgCode, bus.i_trade_type});
    newMsg[1] = timestamp_q;
    newMsg[2] = (msgType == MSG_ADD) ? idCount_q : bus.i_order_ref;
    newMsg[3] = REG_WIDTH'(bus.i_quantity);
    newMsg[4] = REG_WIDTH'(symbolName[63:32]);
    newMsg[5] = REG_WIDTH'(symbolName[31:0]);
    if (msgType == MSG_CANCEL) begin
      newMsg[6] = '0;
    end else if (bus.i_trade_type) begin
      newMsg[6] = bus.i_sell_price;
    end else begin
      newMsg[6] = bus.i_buy_price;
    end
  end

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    timestamp_d = timestamp_q + REG_WIDTH'(1);
    idCount_d   = idCount_q;
    orderId_d   = orderId_q;
    drop_d      = accept && (msgType == MSG_RESERVED);
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (accept && (msgType == MSG_ADD)) begin
      idCount_d = idCount_q + REG_WIDTH'(1);
      orderId_d = idCount_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      timestamp_q <= '0;
      idCount_q   <= ORDER_ID_START;
      orderId_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      timestamp_q <= timestamp_d;
      idCount_q   <= idCount_d;
      orderId_q   <= orderId_d;
      drop_q      <= drop_d;
    end
  end

  // Storage needs no reset: push is impossible while reset is high and empty masks the outputs.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= newMsg;
    end
  end

  assign headMsg = fifoEmpty ? '0 : mem_q[rdPtr_q];

  assign bus.o_valid    = !fifoEmpty;
  assign bus.o_reg_1    = headMsg[0];
  assign bus.o_reg_2    = headMsg[1];
  assign bus.o_reg_3    = headMsg[2];
  assign bus.o_reg_4    = headMsg[3];
  assign bus.o_reg_5    = headMsg[4];
  assign bus.o_reg_6    = headMsg[5];
  assign bus.o_reg_7    = headMsg[6];
  assign bus.o_order_id = orderId_q;
  assign bus.o_drop     = drop_q;

endmodule

// File: tb/tb_itch_order_encoder.sv
// Bench for itch_order_encoder: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based message model.
module tb_itch_order_encoder;
  localparam int REG_WIDTH  = 32;
  localparam int QTY_WIDTH  = 16;
  localparam int NUM_STOCKS = 4;
  localparam int FIFO_DEPTH = 4;

  typedef logic [31:0] word_t;
  typedef logic [6:0][31:0] msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  itch_order_encoder_if #(.REG_WIDTH(REG_WIDTH), .QTY_WIDTH(QTY_WIDTH), .NUM_STOCKS(NUM_STOCKS)) bus();

  itch_order_encoder #(
    .REG_WIDTH(REG_WIDTH), .QTY_WIDTH(QTY_WIDTH), .NUM_STOCKS(NUM_STOCKS),
    .FIFO_DEPTH(FIFO_DEPTH), .ORDER_ID_START(32'd1)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  msg_t  modelQ[$];
  word_t mTs;
  word_t mId;
  word_t mOrderId;
  logic  mDrop;
  bit    checkEn = 1'b0;
  bit    mRdy, mAcc, mPop;

  function automatic msg_t encode(input logic [1:0] t, input logic tr, input logic [1:0] s,
                                  input word_t buy, input word_t sell, input logic [15:0] q,
                                  input word_t oref, input word_t id, input word_t ts);
    msg_t m;
    logic [7:0] code;
    logic [63:0] name;
    code = "A";
    if (t == 2'd1) code = "X";
    if (t == 2'd2) code = "E";
    case (s)
      2'd0: name = "AAPL    ";
      2'd1: name = "AMZN    ";
      2'd2: name = "GOOGL   ";
      default: name = "MSFT    ";
    endcase
    m[0] = {23'd0, code, tr};
    m[1] = ts;
    m[2] = (t == 2'd0) ? id : oref;
    m[3] = {16'd0, q};
    m[4] = name[63:32];
    m[5] = name[31:0];
    m[6] = (t == 2'd1) ? 32'd0 : (tr ? sell : buy);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of encoded messages, updated on each rising edge from sampled inputs.
  always @(posedge clk) begin
    if (rst) begin
      modelQ.delete();
      mTs      = 32'd0;
      mId      = 32'd1;
      mOrderId = 32'd0;
      mDrop    = 1'b0;
      checkEn  = 1'b1;
    end else begin
      mRdy = (modelQ.size() < FIFO_DEPTH) && !bus.i_book_is_busy;
      mAcc = bus.i_data_valid && mRdy;
      mPop = (modelQ.size() > 0) && bus.i_ready;
      if (mPop) void'(modelQ.pop_front());
      mDrop = mAcc && (bus.i_msg_type == 2'd3);
      if (mAcc && bus.i_msg_type != 2'd3)
        modelQ.push_back(encode(bus.i_msg_type, bus.i_trade_type, bus.i_stock_symbol,
                                bus.i_buy_price, bus.i_sell_price, bus.i_quantity,
                                bus.i_order_ref, mId, mTs));
      if (mAcc && bus.i_msg_type == 2'd0) begin
        mOrderId = mId;
        mId      = mId + 32'd1;
      end
      mTs = mTs + 32'd1;
    end
  end

  always @(negedge clk) begin
    msg_t expMsg;
    msg_t dutMsg;
    if (checkEn) begin
      if (modelQ.size() > 0) expMsg = modelQ[0];
      else expMsg = '0;
      dutMsg = {bus.o_reg_7, bus.o_reg_6, bus.o_reg_5, bus.o_reg_4,
                bus.o_reg_3, bus.o_reg_2, bus.o_reg_1};
      checkOutput("o_ready", 32'(bus.o_ready),
                  32'(!rst && (modelQ.size() < FIFO_DEPTH) && !bus.i_book_is_busy));
      checkOutput("o_valid", 32'(bus.o_valid), 32'(modelQ.size() > 0));
      checkOutput("o_order_id", bus.o_order_id, mOrderId);
      checkOutput("o_drop", 32'(bus.o_drop), 32'(mDrop));
      for (int k = 0; k < 7; k++)
        checkOutput($sformatf("o_reg_%0d", k + 1), dutMsg[k], expMsg[k]);
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] t, input logic tr,
                               input logic [1:0] s, input word_t buy, input word_t sell,
                               input logic [15:0] q, input word_t oref, input logic busy,
                               input logic rdy);
    rst                = r;
    bus.i_data_valid   = v;
    bus.i_msg_type     = t;
    bus.i_trade_type   = tr;
    bus.i_stock_symbol = s;
    bus.i_buy_price    = buy;
    bus.i_sell_price   = sell;
    bus.i_quantity     = q;
    bus.i_order_ref    = oref;
    bus.i_book_is_busy = busy;
    bus.i_ready        = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 32'd0, 1'b0, rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic addOrder(input logic tr, input logic [1:0] s, input word_t price,
                          input logic [15:0] q, input logic rdy);
    applyStimulus(1'b0, 1'b1, 2'd0, tr, s, price, price + 32'h100, q, 32'd0, 1'b0, rdy);
  endtask

  word_t expRef[4];

  initial begin
    bus.i_data_valid = 1'b0;
    bus.i_ready      = 1'b0;

    // Scenario 1: first ADD after reset, captured at timestamp 5.
    doReset();
    checkOutput("reset_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("reset_order_id", bus.o_order_id, 32'd0);
    checkOutput("reset_reg_1", bus.o_reg_1, 32'd0);
    repeat (5) idle(1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'hBABB, 32'h1111, 16'd100, 32'd0, 1'b0, 1'b0);
    checkOutput("s1_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("s1_reg_1", bus.o_reg_1, 32'h82);
    checkOutput("s1_reg_2", bus.o_reg_2, 32'd5);
    checkOutput("s1_reg_3", bus.o_reg_3, 32'd1);
    checkOutput("s1_reg_4", bus.o_reg_4, 32'd100);
    checkOutput("s1_reg_5", bus.o_reg_5, 32'h4141504C);
    checkOutput("s1_reg_6", bus.o_reg_6, 32'h20202020);
    checkOutput("s1_reg_7", bus.o_reg_7, 32'hBABB);
    checkOutput("s1_order_id", bus.o_order_id, 32'd1);
    checkOutput("s1_model_ts", modelQ[0][1], 32'd5);
    checkOutput("s1_model_reg_1", modelQ[0][0], 32'h82);

    // Scenario 2: three ADDs then a SELL GOOGL CANCEL of ref 2, drained in order.
    doReset();
    addOrder(1'b0, 2'd1, 32'h10, 16'd1, 1'b0);
    addOrder(1'b1, 2'd3, 32'h20, 16'd2, 1'b0);
    addOrder(1'b0, 2'd2, 32'h30, 16'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 32'h55, 32'h1234, 16'd7, 32'd2, 1'b0, 1'b0);
    expRef = '{32'd1, 32'd2, 32'd3, 32'd2};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("s2_reg_3_%0d", k), bus.o_reg_3, expRef[k]);
      if (k == 3) begin
        checkOutput("s2_cancel_reg_1", bus.o_reg_1, 32'hB1);
        checkOutput("s2_cancel_reg_6", bus.o_reg_6, 32'h4C202020);
        checkOutput("s2_cancel_reg_7", bus.o_reg_7, 32'd0);
      end
      idle(1'b1);
    end
    checkOutput("s2_drained", 32'(bus.o_valid), 32'd0);

    // Scenario 3: fill with downstream stalled, hold a fifth request until full clears.
    doReset();
    for (int k = 0; k < 4; k++) addOrder(1'b0, 2'(k), 32'h40 + 32'(k), 16'(k + 1), 1'b0);
    checkOutput("s3_full_ready", 32'(bus.o_ready), 32'd0);
    addOrder(1'b1, 2'd0, 32'h99, 16'd5, 1'b0);
    checkOutput("s3_held_id", bus.o_order_id, 32'd4);
    addOrder(1'b1, 2'd0, 32'h99, 16'd5, 1'b1);
    checkOutput("s3_pop_no_accept", bus.o_order_id, 32'd4);
    addOrder(1'b1, 2'd0, 32'h99, 16'd5, 1'b0);
    checkOutput("s3_fifth_id", bus.o_order_id, 32'd5);
    expRef = '{32'd2, 32'd3, 32'd4, 32'd5};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("s3_reg_3_%0d", k), bus.o_reg_3, expRef[k]);
      idle(1'b1);
    end

    // Scenario 4: book busy blocks acceptance and leaves the id counter alone.
    doReset();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h7, 32'h8, 16'd9, 32'd0, 1'b1, 1'b0);
    checkOutput("s4_busy_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("s4_busy_valid", 32'(bus.o_valid), 32'd0);
    addOrder(1'b0, 2'd0, 32'h7, 16'd9, 1'b0);
    checkOutput("s4_id_unchanged", bus.o_reg_3, 32'd1);

    // Scenario 5: reserved type is dropped without touching the counters.
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd1, 32'h1, 32'h2, 16'd3, 32'h4, 1'b0, 1'b1);
    checkOutput("s5_drop", 32'(bus.o_drop), 32'd1);
    checkOutput("s5_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("s5_order_id", bus.o_order_id, 32'd1);
    idle(1'b0);
    checkOutput("s5_drop_clear", 32'(bus.o_drop), 32'd0);
    addOrder(1'b0, 2'd1, 32'h3, 16'd3, 1'b0);
    checkOutput("s5_next_id", bus.o_reg_3, 32'd2);

    // Scenario 6: reset with messages buffered discards them all.
    doReset();
    for (int k = 0; k < 3; k++) addOrder(1'b1, 2'd2, 32'h60, 16'd4, 1'b0);
    doReset();
    checkOutput("s6_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("s6_order_id", bus.o_order_id, 32'd0);
    checkOutput("s6_reg_2", bus.o_reg_2, 32'd0);
    checkOutput("s6_reg_7", bus.o_reg_7, 32'd0);
    addOrder(1'b0, 2'd0, 32'h61, 16'd4, 1'b0);
    checkOutput("s6_first_id", bus.o_reg_3, 32'd1);

    // Random traffic, judged entirely by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom, $urandom, 16'($urandom),
                    32'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1);
    end
    idle(1'b1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
